// File: rtl/rv32e_pkg.sv
// Purpose: shared widths, constants and the fetch entry type for the rv32e front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32e_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_STEP       = 32'd4;
  localparam logic [ILEN-1:0] RV_NOP        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RESET_PC_DFLT = 32'h0000_0000;

  // One prefetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; the low two address bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32e_fetch_fifo.sv
// Purpose: small circular prefetch buffer of fetch_entry_t between the ROM and decode.
// Latency: a pushed entry is visible at head on the cycle after the push edge.
// Backpressure: caller must not push when full unless popping the same cycle; flush wins.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   flush           synchronous clear of pointers and count (drops all entries)
//   push, push_data write an entry at the tail
//   pop             advance the head (caller guarantees non-empty)
//   head            entry at the read pointer
//   count, full, empty  occupancy status
module rv32e_fetch_fifo
  import rv32e_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  fetch_entry_t mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // A pop coinciding with a flush is consumed by the flush, so the count
      // goes straight to zero rather than being decremented.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through head when count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);

endmodule

// File: rtl/rv32e_fetch_unit.sv
// Purpose: instruction-fetch front end; owns fetch PC, drives ROM address, buffers {pc, instr} for decode.
// Latency: ROM word at fetch_pc reaches instr/instr_valid one cycle later (empty buffer); redirect target two cycles after the pulse.
// Backpressure: instr_ready=0 stalls fetch once the prefetch buffer is full; 1 instr/cycle sustained with ready high.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   mem_program_addr_bus    ROM byte address (= fetch PC, word aligned)
//   mem_program_data_bus    combinational ROM read data for that address
//   redirect_valid/_pc      one-cycle restart request from execute
//   instr_valid/instr/instr_pc/instr_ready   valid/ready handoff to decode
module rv32e_fetch_unit
  import rv32e_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DFLT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] mem_program_addr_bus,
  input  logic [ILEN-1:0] mem_program_data_bus,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

  logic            push;
  logic            pop;
  fetch_entry_t    push_data;
  fetch_entry_t    fifo_head;
  logic [AW:0]     fifo_count;
  logic            fifo_full;
  logic            fifo_empty;

  assign instr_valid = (fifo_count != '0);
  assign pop         = instr_valid & instr_ready;

  // A full buffer can still accept a word when decode drains the head in the
  // same cycle, which is what keeps throughput at one per cycle.
  assign push        = !redirect_valid && (!fifo_full || pop);

  assign push_data.pc    = fetch_pc_q;
  assign push_data.instr = mem_program_data_bus;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;  // modulo 2^32, wraps silently
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  rv32e_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign mem_program_addr_bus = fetch_pc_q;

  // With nothing buffered, decode sees a NOP tagged with the address being fetched.
  assign instr    = fifo_empty ? RV_NOP     : fifo_head.instr;
  assign instr_pc = fifo_empty ? fetch_pc_q : fifo_head.pc;

endmodule

// File: tb/tb_rv32e_fetch_unit.sv
// Purpose: directed self-checking bench for rv32e_fetch_unit with a combinational ROM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rv32e_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_program_addr_bus;
  logic [31:0] mem_program_data_bus;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  // ROM image: word[i] = 0xA000_0000 | i.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA000_0000 | {2'b00, a[31:2]};
  endfunction

  assign mem_program_data_bus = rom_word(mem_program_addr_bus);

  rv32e_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .mem_program_addr_bus (mem_program_addr_bus),
    .mem_program_data_bus (mem_program_data_bus),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .instr_valid          (instr_valid),
    .instr                (instr),
    .instr_pc             (instr_pc),
    .instr_ready          (instr_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [31:0] addr);
    chk({tag, ".vld"},  {31'b0, instr_valid}, {31'b0, vld});
    chk({tag, ".ins"},  instr, ins);
    chk({tag, ".pc"},   instr_pc, pc);
    chk({tag, ".addr"}, mem_program_addr_bus, addr);
  endtask

  // Advance one cycle and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1) streaming from reset with decode always ready
    do_reset();
    instr_ready = 1'b1;
    chk_out("rst", 1'b0, NOP, 32'h0, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_out($sformatf("stream%0d", k), 1'b1, 32'hA000_0000 | (k - 1),
              32'(4 * (k - 1)), 32'(4 * k));
    end

    // 2) stall: buffer fills, fetch holds at 8, head holds pc 0
    do_reset();
    instr_ready = 1'b0;
    chk_out("stall0", 1'b0, NOP, 32'h0, 32'h0);
    step();
    chk_out("stall1", 1'b1, 32'hA000_0000, 32'h0, 32'h4);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk_out($sformatf("stall%0d", k), 1'b1, 32'hA000_0000, 32'h0, 32'h8);
    end
    step();
    instr_ready = 1'b1;
    chk_out("drain0", 1'b1, 32'hA000_0000, 32'h0, 32'h8);
    step();
    chk_out("drain1", 1'b1, 32'hA000_0001, 32'h4, 32'hC);
    step();
    chk_out("drain2", 1'b1, 32'hA000_0002, 32'h8, 32'h10);
    step();
    chk_out("drain3", 1'b1, 32'hA000_0003, 32'hC, 32'h14);

    // 3) redirect to misaligned 0x103 while full and not popping
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    chk_out("redir1", 1'b0, NOP, 32'h100, 32'h100);
    step();
    chk_out("redir2", 1'b1, 32'hA000_0040, 32'h100, 32'h104);
    step();
    chk_out("redir3", 1'b1, 32'hA000_0041, 32'h104, 32'h108);

    // 4) redirect near the top of the address space, wrap without a stall
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    chk_out("wrap0", 1'b0, NOP, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
    step();
    chk_out("wrap1", 1'b1, 32'hBFFF_FFFE, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    step();
    chk_out("wrap2", 1'b1, 32'hBFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000);
    step();
    chk_out("wrap3", 1'b1, 32'hA000_0000, 32'h0000_0000, 32'h0000_0004);

    // 5) asynchronous reset between edges with two entries buffered
    instr_ready = 1'b0;
    step();
    chk_out("prerst", 1'b1, 32'hA000_0000, 32'h0, 32'h8);
    #3;
    reset = 1'b1;
    #1;
    chk_out("arst", 1'b0, NOP, 32'h0, 32'h0);
    step();
    reset       = 1'b0;
    instr_ready = 1'b1;
    chk_out("arst_rel", 1'b0, NOP, 32'h0, 32'h0);
    step();
    chk_out("resume", 1'b1, 32'hA000_0000, 32'h0, 32'h4);

    // 6) redirect and pop in the same cycle
    step();
    chk_out("rpop0", 1'b1, 32'hA000_0001, 32'h4, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    chk_out("rpop1", 1'b0, NOP, 32'h200, 32'h200);
    step();
    chk_out("rpop2", 1'b1, 32'hA000_0080, 32'h200, 32'h204);
    step();
    chk_out("rpop3", 1'b1, 32'hA000_0081, 32'h204, 32'h208);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
